// File: rtl/brew_sequencer.sv
// Coffee-brew sequencer: IDLE -> HEAT -> BREW -> (MILK) -> DONE with a BCD mm:ss countdown display.
// Optional macro BREW_ABORT_EN lets a T edge abort an active phase back to IDLE.
module brew_sequencer #(
    parameter int unsigned TICK_DIV = 10000000,
    parameter int unsigned T_HEAT   = 30,
    parameter int unsigned T_BREW   = 20,
    parameter int unsigned T_MILK   = 10,
    parameter int unsigned T_DONE   = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       agua,
    input  logic       cafe,
    input  logic       leche,
    input  logic       quiereLeche,
    input  logic       T,
    output logic [2:0] TH_M,
    output logic [3:0] d3,
    output logic [3:0] d2,
    output logic [3:0] d1,
    output logic [3:0] d0,
    output logic       busy,
    output logic       fault
);

    typedef enum logic [2:0] {StIdle, StHeat, StBrew, StMilk, StDone, StFault} state_e;

    localparam int unsigned DivW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DivW-1:0] DivLast = DivW'(TICK_DIV - 1);

`ifdef BREW_ABORT_EN
    localparam bit AbortEn = 1'b1;
`else
    localparam bit AbortEn = 1'b0;
`endif

    function automatic logic [15:0] to_bcd(input int unsigned secs);
        int unsigned mm;
        int unsigned ss;
        mm = secs / 60;
        ss = secs % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    // Decrement mm:ss in BCD; ss=00 borrows to 59.
    function automatic logic [15:0] bcd_dec(input logic [15:0] t);
        logic [3:0] m1, m0, s1, s0;
        {m1, m0, s1, s0} = t;
        if (s1 == 4'd0 && s0 == 4'd0) begin
            s1 = 4'd5;
            s0 = 4'd9;
            if (m0 == 4'd0) begin
                m0 = 4'd9;
                m1 = m1 - 4'd1;
            end else begin
                m0 = m0 - 4'd1;
            end
        end else if (s0 == 4'd0) begin
            s0 = 4'd9;
            s1 = s1 - 4'd1;
        end else begin
            s0 = s0 - 4'd1;
        end
        return {m1, m0, s1, s0};
    endfunction

    localparam logic [15:0] LoadHeat = to_bcd(T_HEAT);
    localparam logic [15:0] LoadBrew = to_bcd(T_BREW);
    localparam logic [15:0] LoadMilk = to_bcd(T_MILK);
    localparam logic [15:0] LoadDone = to_bcd(T_DONE);

    state_e          state_q, state_d;
    logic [DivW-1:0] div_q, div_d;
    logic [15:0]     tmr_q, tmr_d;
    logic [2:0]      th_m_q, th_m_d;
    logic            t_q;
    logic            block_q;
    logic            milk_q, milk_d;
    logic            t_edge;
    logic            tick;
    logic            expire;
    logic            timed;

    // block_q keeps a T held high across reset release from counting as an edge.
    assign t_edge = T & ~t_q & ~block_q;
    assign timed  = (state_q == StHeat) || (state_q == StBrew) ||
                    (state_q == StMilk) || (state_q == StDone);
    assign tick   = timed && (div_q == DivLast);
    assign expire = tick && (tmr_q == 16'h0001);

    always_comb begin
        state_d = state_q;
        milk_d  = milk_q;
        unique case (state_q)
            StIdle: begin
                if (t_edge) begin
                    if (agua && cafe && (leche || !quiereLeche)) begin
                        state_d = StHeat;
                        milk_d  = quiereLeche;
                    end else begin
                        state_d = StFault;
                    end
                end
            end
            StHeat: begin
                if (!agua)                  state_d = StFault;
                else if (AbortEn && t_edge) state_d = StIdle;
                else if (expire)            state_d = StBrew;
            end
            StBrew: begin
                if (!agua || !cafe)         state_d = StFault;
                else if (AbortEn && t_edge) state_d = StIdle;
                else if (expire)            state_d = milk_q ? StMilk : StDone;
            end
            StMilk: begin
                if (!leche)                 state_d = StFault;
                else if (AbortEn && t_edge) state_d = StIdle;
                else if (expire)            state_d = StDone;
            end
            StDone: begin
                if (expire) state_d = StIdle;
            end
            StFault: begin
                if (t_edge) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        div_d = div_q;
        tmr_d = tmr_q;
        if (state_d != state_q) begin
            div_d = '0;
            unique case (state_d)
                StHeat:  tmr_d = LoadHeat;
                StBrew:  tmr_d = LoadBrew;
                StMilk:  tmr_d = LoadMilk;
                StDone:  tmr_d = LoadDone;
                default: tmr_d = 16'h0000;
            endcase
        end else if (!timed) begin
            div_d = '0;
        end else if (tick) begin
            div_d = '0;
            tmr_d = bcd_dec(tmr_q);
        end else begin
            div_d = div_q + DivW'(1);
        end
    end

    always_comb begin
        th_m_d = 3'b000;
        unique case (state_d)
            StHeat:  th_m_d = 3'b100;
            StBrew:  th_m_d = 3'b110;
            StMilk:  th_m_d = 3'b001;
            default: th_m_d = 3'b000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            div_q   <= '0;
            tmr_q   <= 16'h0000;
            th_m_q  <= 3'b000;
            t_q     <= 1'b0;
            block_q <= 1'b1;
            milk_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            tmr_q   <= tmr_d;
            th_m_q  <= th_m_d;
            t_q     <= T;
            block_q <= block_q & T;
            milk_q  <= milk_d;
        end
    end

    always_comb begin
        {d3, d2, d1, d0} = 16'h0000;
        unique case (state_q)
            StHeat, StBrew, StMilk, StDone: {d3, d2, d1, d0} = tmr_q;
            StFault:                        {d3, d2, d1, d0} = 16'hFFFF;
            default:                        {d3, d2, d1, d0} = 16'h0000;
        endcase
    end

    assign TH_M  = th_m_q;
    assign busy  = (state_q == StHeat) || (state_q == StBrew) || (state_q == StMilk);
    assign fault = (state_q == StFault);

endmodule

// File: tb/tb_brew_sequencer.sv
// Directed self-checking bench for brew_sequencer with short phase timings.
module tb_brew_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       agua = 1'b1, cafe = 1'b1, leche = 1'b1, quiereLeche = 1'b1, T = 1'b0;
    logic [2:0] TH_M, th_m2;
    logic [3:0] d3, d2, d1, d0, e3, e2, e1, e0;
    logic       busy, fault, busy2, fault2;
    logic [15:0] disp, disp2;

    int passed = 0;
    int total  = 0;

    assign disp  = {d3, d2, d1, d0};
    assign disp2 = {e3, e2, e1, e0};

    always #5 clk = ~clk;

    brew_sequencer #(
        .TICK_DIV(4), .T_HEAT(3), .T_BREW(2), .T_MILK(2), .T_DONE(1)
    ) dut (
        .clk(clk), .reset(reset), .agua(agua), .cafe(cafe), .leche(leche),
        .quiereLeche(quiereLeche), .T(T), .TH_M(TH_M),
        .d3(d3), .d2(d2), .d1(d1), .d0(d0), .busy(busy), .fault(fault)
    );

    // Long heat phase to exercise the minute borrow.
    brew_sequencer #(
        .TICK_DIV(2), .T_HEAT(61), .T_BREW(1), .T_MILK(1), .T_DONE(1)
    ) dut2 (
        .clk(clk), .reset(reset), .agua(agua), .cafe(cafe), .leche(leche),
        .quiereLeche(quiereLeche), .T(T), .TH_M(th_m2),
        .d3(e3), .d2(e2), .d1(e1), .d0(e0), .busy(busy2), .fault(fault2)
    );

    function automatic logic [15:0] bcd(input int secs);
        return {4'(secs / 600), 4'((secs / 60) % 10), 4'((secs % 60) / 10), 4'(secs % 10)};
    endfunction

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        T = 1'b0; agua = 1'b1; cafe = 1'b1; leche = 1'b1; quiereLeche = 1'b1;
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        step(1);
    endtask

    task automatic pulse_t();
        T = 1'b1;
        step(1);
        T = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(2);
        total++;
        if ({TH_M, disp, busy, fault} !== {3'b000, 16'h0000, 1'b0, 1'b0}) begin
            $display("FAIL reset_outputs: got th_m=%b disp=%h busy=%b fault=%b want 000 0000 0 0",
                     TH_M, disp, busy, fault);
        end else passed++;
        do_reset();
    endtask

    task automatic test_full();
        do_reset();
        pulse_t();
        for (int k = 0; k < 12; k++) begin
            total++;
            if ({TH_M, busy, disp} !== {3'b100, 1'b1, bcd(3 - k / 4)}) begin
                $display("FAIL full_heat cyc %0d: got th_m=%b busy=%b disp=%h want 100 1 %h",
                         k, TH_M, busy, disp, bcd(3 - k / 4));
            end else passed++;
            step(1);
        end
        for (int k = 0; k < 8; k++) begin
            total++;
            if ({TH_M, busy, disp} !== {3'b110, 1'b1, bcd(2 - k / 4)}) begin
                $display("FAIL full_brew cyc %0d: got th_m=%b busy=%b disp=%h want 110 1 %h",
                         k, TH_M, busy, disp, bcd(2 - k / 4));
            end else passed++;
            step(1);
        end
        for (int k = 0; k < 8; k++) begin
            total++;
            if ({TH_M, busy, disp} !== {3'b001, 1'b1, bcd(2 - k / 4)}) begin
                $display("FAIL full_milk cyc %0d: got th_m=%b busy=%b disp=%h want 001 1 %h",
                         k, TH_M, busy, disp, bcd(2 - k / 4));
            end else passed++;
            step(1);
        end
        for (int k = 0; k < 4; k++) begin
            total++;
            if ({TH_M, busy, fault, disp} !== {3'b000, 1'b0, 1'b0, 16'h0001}) begin
                $display("FAIL full_done cyc %0d: got th_m=%b busy=%b fault=%b disp=%h want 000 0 0 0001",
                         k, TH_M, busy, fault, disp);
            end else passed++;
            step(1);
        end
        total++;
        if ({TH_M, busy, disp} !== {3'b000, 1'b0, 16'h0000}) begin
            $display("FAIL full_idle: got th_m=%b busy=%b disp=%h want 000 0 0000", TH_M, busy, disp);
        end else passed++;
    endtask

    task automatic test_no_milk();
        int n;
        bit saw_milk;
        do_reset();
        quiereLeche = 1'b0;
        leche = 1'b0;
        pulse_t();
        n = 0;
        saw_milk = 1'b0;
        while (busy && n < 100) begin
            if (TH_M == 3'b001) saw_milk = 1'b1;
            n++;
            step(1);
        end
        total++;
        if (n !== 20) $display("FAIL no_milk_busy_cycles: got %0d want 20", n);
        else passed++;
        total++;
        if (saw_milk !== 1'b0) $display("FAIL no_milk_valve: got milk valve on want never");
        else passed++;
        total++;
        if ({TH_M, disp} !== {3'b000, 16'h0001}) begin
            $display("FAIL no_milk_done: got th_m=%b disp=%h want 000 0001", TH_M, disp);
        end else passed++;
    endtask

    task automatic test_fault_cafe();
        do_reset();
        cafe = 1'b0;
        pulse_t();
        step(3);
        total++;
        if ({fault, busy, TH_M, disp} !== {1'b1, 1'b0, 3'b000, 16'hFFFF}) begin
            $display("FAIL cafe_fault: got fault=%b busy=%b th_m=%b disp=%h want 1 0 000 ffff",
                     fault, busy, TH_M, disp);
        end else passed++;
        cafe = 1'b1;
        pulse_t();
        total++;
        if ({fault, busy, disp} !== {1'b0, 1'b0, 16'h0000}) begin
            $display("FAIL cafe_fault_clear: got fault=%b busy=%b disp=%h want 0 0 0000",
                     fault, busy, disp);
        end else passed++;
    endtask

    task automatic test_agua_drop();
        do_reset();
        pulse_t();
        step(4);
        total++;
        if ({TH_M, disp} !== {3'b100, 16'h0002}) begin
            $display("FAIL agua_heat5: got th_m=%b disp=%h want 100 0002", TH_M, disp);
        end else passed++;
        agua = 1'b0;
        step(1);
        total++;
        if ({fault, busy, TH_M, disp} !== {1'b1, 1'b0, 3'b000, 16'hFFFF}) begin
            $display("FAIL agua_fault: got fault=%b busy=%b th_m=%b disp=%h want 1 0 000 ffff",
                     fault, busy, TH_M, disp);
        end else passed++;
        agua = 1'b1;
    endtask

    task automatic test_reset_mid_brew();
        int bad;
        do_reset();
        pulse_t();
        step(14);
        total++;
        if (TH_M !== 3'b110) $display("FAIL rst_brew_entry: got th_m=%b want 110", TH_M);
        else passed++;
        T = 1'b1;
        reset = 1'b1;
        step(1);
        total++;
        if ({TH_M, disp, busy, fault} !== {3'b000, 16'h0000, 1'b0, 1'b0}) begin
            $display("FAIL rst_mid_brew: got th_m=%b disp=%h busy=%b fault=%b want 000 0000 0 0",
                     TH_M, disp, busy, fault);
        end else passed++;
        step(2);
        reset = 1'b0;
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            step(1);
            if (busy || TH_M != 3'b000) bad++;
        end
        total++;
        if (bad !== 0) $display("FAIL rst_t_held: got %0d busy cycles want 0", bad);
        else passed++;
        T = 1'b0;
        step(1);
        pulse_t();
        total++;
        if ({busy, TH_M, disp} !== {1'b1, 3'b100, 16'h0003}) begin
            $display("FAIL rst_restart: got busy=%b th_m=%b disp=%h want 1 100 0003",
                     busy, TH_M, disp);
        end else passed++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        T = 1'b1;
        step(1);
        step(32);
        total++;
        if ({busy, TH_M, disp} !== {1'b0, 3'b000, 16'h0000}) begin
            $display("FAIL hold_t_idle: got busy=%b th_m=%b disp=%h want 0 000 0000", busy, TH_M, disp);
        end else passed++;
        step(3);
        total++;
        if (busy !== 1'b0) $display("FAIL hold_t_no_retrigger: got busy=%b want 0", busy);
        else passed++;
        T = 1'b0;
        step(1);
        pulse_t();
        total++;
        if ({busy, TH_M} !== {1'b1, 3'b100}) begin
            $display("FAIL second_start: got busy=%b th_m=%b want 1 100", busy, TH_M);
        end else passed++;
    endtask

    task automatic test_borrow();
        do_reset();
        pulse_t();
        total++;
        if (disp2 !== 16'h0101) $display("FAIL borrow_load: got %h want 0101", disp2);
        else passed++;
        step(2);
        total++;
        if (disp2 !== 16'h0100) $display("FAIL borrow_0100: got %h want 0100", disp2);
        else passed++;
        step(2);
        total++;
        if (disp2 !== 16'h0059) $display("FAIL borrow_0059: got %h want 0059", disp2);
        else passed++;
        step(2);
        total++;
        if (disp2 !== 16'h0058) $display("FAIL borrow_0058: got %h want 0058", disp2);
        else passed++;
    endtask

    task automatic test_abort();
        do_reset();
        pulse_t();
        step(13);
        pulse_t();
`ifdef BREW_ABORT_EN
        total++;
        if ({busy, TH_M, disp} !== {1'b0, 3'b000, 16'h0000}) begin
            $display("FAIL abort_idle: got busy=%b th_m=%b disp=%h want 0 000 0000", busy, TH_M, disp);
        end else passed++;
`else
        total++;
        if ({busy, TH_M, disp} !== {1'b1, 3'b110, 16'h0002}) begin
            $display("FAIL no_abort_brew: got busy=%b th_m=%b disp=%h want 1 110 0002",
                     busy, TH_M, disp);
        end else passed++;
        step(6);
        total++;
        if ({busy, TH_M} !== {1'b1, 3'b001}) begin
            $display("FAIL no_abort_milk: got busy=%b th_m=%b want 1 001", busy, TH_M);
        end else passed++;
`endif
    endtask

    initial begin
        test_reset();
        test_full();
        test_no_milk();
        test_fault_cafe();
        test_agua_drop();
        test_reset_mid_brew();
        test_back_to_back();
        test_borrow();
        test_abort();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/brew_sequencer.md
BREW_SEQUENCER -- requirements
Module: brew_sequencer

Interface
REQ-001 SHALL have parameter TICK_DIV, default 10000000, clk cycles per 1 s tick at 10 MHz.
REQ-002 SHALL have parameter T_HEAT, default 30, heat phase length in seconds.
REQ-003 SHALL have parameter T_BREW, default 20, brew phase length in seconds.
REQ-004 SHALL have parameter T_MILK, default 10, milk phase length in seconds.
REQ-005 SHALL have parameter T_DONE, default 3, done-hold length in seconds; all T_* are 1..3599.
REQ-006 SHALL have port clk, input, 1, single system clock; all logic on its rising edge.
REQ-007 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-008 SHALL have ports agua, cafe, leche, input, 1 each, ingredient-present sensors, synchronous to clk.
REQ-009 SHALL have port quiereLeche, input, 1, milk requested, sampled at start.
REQ-010 SHALL have port T, input, 1, debounced start button, level.
REQ-011 SHALL have port TH_M, output, 3, actuators [2]=heater, [1]=brew pump, [0]=milk valve.
REQ-012 SHALL have ports d3, d2, d1, d0, output, 4 each, BCD remaining time mm:ss (d3 = minute tens, d0 = second units) for Disp7Seg.
REQ-013 SHALL have port busy, output, 1, high in HEAT, BREW, MILK.
REQ-014 SHALL have port fault, output, 1, high in FAULT.

Function
REQ-015 SHALL detect a T rising edge as T high with its registered copy low; only edges act, and holding T high SHALL NOT retrigger.
REQ-016 SHALL implement states IDLE, HEAT, BREW, MILK, DONE, FAULT.
REQ-017 IDLE: on a T edge with agua&cafe, and leche if quiereLeche, SHALL go to HEAT and latch quiereLeche.
REQ-018 IDLE: on a T edge with any required ingredient absent, SHALL go to FAULT.
REQ-019 HEAT->BREW, BREW->MILK if latched milk else DONE, MILK->DONE, DONE->IDLE, each on expiry of its own phase.
REQ-020 Losing agua (HEAT, BREW), cafe (BREW) or leche (MILK) mid-phase SHALL go to FAULT on the next edge.
REQ-021 FAULT: a T edge SHALL go to IDLE, and SHALL be ignored otherwise.
REQ-022 TH_M SHALL be 3'b100 in HEAT, 3'b110 in BREW, 3'b001 in MILK, and 3'b000 in all other states; it SHALL be registered and change on the same edge as the state.
REQ-023 The timer SHALL be a BCD mm:ss down-counter loaded with the phase length on state entry; on ss=00 with a tick it SHALL borrow to 59 and decrement mm.
REQ-024 The tick divider SHALL clear on every state change, so each phase lasts exactly T_x*TICK_DIV cycles.
REQ-025 The phase SHALL expire on the tick where the timer reads 00:01, so the display shows N..1 and never 00:00 inside a phase.
REQ-026 d3..d0 SHALL show the timer in HEAT, BREW, MILK and DONE, 0000 in IDLE, and 4'hF on all digits in FAULT.
REQ-027 If a fault condition and phase expiry coincide, FAULT SHALL win.

Reset
REQ-028 reset SHALL force IDLE, TH_M=000, digits=0000, busy=0, fault=0, divider=0 and the T edge register=0 on the next clk edge, overriding any state mid-brew.
REQ-029 A T held high through reset release SHALL NOT start a brew.

Configuration
REQ-030 Macro BREW_ABORT_EN defined: a T edge in HEAT, BREW or MILK SHALL go to IDLE next cycle with actuators off.
REQ-031 Macro BREW_ABORT_EN undefined: T SHALL be ignored in HEAT, BREW, MILK and DONE.

Verification (TICK_DIV=4, T_HEAT=3, T_BREW=2, T_MILK=2, T_DONE=1)
REQ-032 All inputs high, T pulsed -> HEAT for 12 cycles (TH_M=100, display 0003->0001), BREW for 8 cycles (110), MILK for 8 cycles (001), DONE for 4 cycles, then IDLE.
REQ-033 quiereLeche=0, leche=0, T pulsed -> no MILK; BREW goes to DONE; total busy time is 20 cycles.
REQ-034 cafe=0, T pulsed -> FAULT, digits FFFF, TH_M=000; a second T edge returns to IDLE.
REQ-035 agua dropped on the 5th cycle of HEAT -> FAULT next edge, TH_M=000, busy=0.
REQ-036 reset asserted mid-BREW with T held high -> IDLE, outputs zero; after release no start until T goes low then high.
REQ-037 BREW_ABORT_EN defined, T edge in BREW -> IDLE next cycle; undefined -> brew completes unchanged.
